// File: rtl/sprdma.sv
// Sprite DMA: a CPU write to TRIG_ADDR stalls the CPU, then 256 bytes are copied from
// page {data, 8'h00} to OAM_ADDR using alternating read/write bus cycles.
module sprdma #(
  parameter int unsigned CYC_CLKS  = 4,
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ready,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_nw,
  input  logic [7:0]  mem_din,
  output logic        active,
  output logic        cpu_ready,
  output logic [15:0] sprdma_a,
  output logic [7:0]  sprdma_dout,
  output logic        sprdma_r_nw
);

  localparam int unsigned CntW = (CYC_CLKS > 2) ? $clog2(CYC_CLKS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CYC_CLKS - 1);

  typedef enum logic [2:0] {StIdle, StWait, StDummy, StRead, StWrite} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      idx_q;
  logic [7:0]      page_q;
  logic            trig_q;
  logic            active_q;
  logic            cpu_ready_q;
  logic [15:0]     a_q;
  logic [7:0]      dout_q;
  logic            r_nw_q;

  logic trig;
  logic cyc_last;

  assign trig     = (cpu_a == TRIG_ADDR) && !cpu_r_nw;
  assign cyc_last = (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= 8'h00;
      page_q      <= 8'h00;
      trig_q      <= 1'b0;
      active_q    <= 1'b0;
      cpu_ready_q <= 1'b1;
      a_q         <= 16'h0000;
      dout_q      <= 8'h00;
      r_nw_q      <= 1'b1;
    end else if (ready) begin
      trig_q <= trig;
      unique case (state_q)
        StIdle: begin
          if (trig && !trig_q) begin
            page_q  <= cpu_dout;
            state_q <= StWait;
          end
        end
        // Let the triggering CPU write finish before taking the bus.
        StWait: begin
          if (!trig) begin
            state_q     <= StDummy;
            idx_q       <= 8'h00;
            cnt_q       <= '0;
            active_q    <= 1'b1;
            cpu_ready_q <= 1'b0;
            a_q         <= {page_q, 8'h00};
            r_nw_q      <= 1'b1;
          end
        end
        StDummy: begin
          if (cyc_last) begin
            cnt_q   <= '0;
            state_q <= StRead;
            a_q     <= {page_q, idx_q};
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRead: begin
          if (cyc_last) begin
            cnt_q   <= '0;
            dout_q  <= mem_din;
            state_q <= StWrite;
            a_q     <= OAM_ADDR;
            r_nw_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWrite: begin
          if (cyc_last) begin
            cnt_q  <= '0;
            r_nw_q <= 1'b1;
            if (idx_q == 8'hFF) begin
              state_q     <= StIdle;
              active_q    <= 1'b0;
              cpu_ready_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + 8'd1;
              a_q     <= {page_q, idx_q + 8'd1};
              state_q <= StRead;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign active      = active_q;
  assign cpu_ready   = cpu_ready_q;
  assign sprdma_a    = a_q;
  assign sprdma_dout = dout_q;
  assign sprdma_r_nw = r_nw_q;

endmodule

// File: tb/tb_sprdma.sv
// Self-checking bench for sprdma: table-driven CPU bus operations plus directed
// sequences, with a scoreboard of expected (read address, OAM data) pairs.
module tb_sprdma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_r_nw;
  logic [7:0]  mem_din;
  logic        active;
  logic        cpu_ready;
  logic [15:0] sprdma_a;
  logic [7:0]  sprdma_dout;
  logic        sprdma_r_nw;

  sprdma dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready      (ready),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .cpu_r_nw   (cpu_r_nw),
    .mem_din    (mem_din),
    .active     (active),
    .cpu_ready  (cpu_ready),
    .sprdma_a   (sprdma_a),
    .sprdma_dout(sprdma_dout),
    .sprdma_r_nw(sprdma_r_nw)
  );

  always #5 clk = ~clk;

  // Memory image: page 3 holds idx ^ 5A; other pages are distinct so a wrong page shows up.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h03;
  endfunction

  assign mem_din = mem_val(sprdma_a);

  typedef struct {
    logic [15:0] rd_addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  int last_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_page(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      exp_t e;
      e.rd_addr = {page, 8'(i)};
      e.data    = mem_val({page, 8'(i)});
      sb_q.push_back(e);
    end
  endtask

  task automatic cpu_op(input logic [15:0] a, input logic r_nw, input logic [7:0] d,
                        input int n);
    cpu_a    = a;
    cpu_r_nw = r_nw;
    cpu_dout = d;
    repeat (n) step();
    cpu_a    = 16'h0000;
    cpu_r_nw = 1'b1;
    cpu_dout = 8'h00;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((active || !cpu_ready) && n < budget) begin
      step();
      n++;
    end
    chk("done_timeout", (n >= budget) ? 1 : 0, 0);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [15:0] a, input logic rnw, input int budget);
    int n = 0;
    while (!(active && sprdma_a == a && sprdma_r_nw == rnw) && n < budget) begin
      step();
      n++;
    end
    chk("addr_timeout", (n >= budget) ? 1 : 0, 0);
  endtask

  // Monitor: one scoreboard pop per WRITE bus cycle, plus stall-length measurement.
  initial begin : monitor
    logic        prev_rnw = 1'b1;
    logic        prev_act = 1'b0;
    logic        prev_rdy = 1'b1;
    logic [15:0] last_rd  = 16'h0000;
    int          low_run  = 0;
    forever begin
      @(negedge clk);
      if (active && !prev_act) xfers++;
      if (active && !sprdma_r_nw && prev_rnw) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_write", 32'(sprdma_a), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rd_addr", 32'(last_rd), 32'(e.rd_addr));
          chk("wr_addr", 32'(sprdma_a), 32'h2004);
          chk("wr_data", 32'(sprdma_dout), 32'(e.data));
        end
      end
      if (active && sprdma_r_nw) last_rd = sprdma_a;
      if (cpu_ready && !prev_rdy) last_stall = low_run;
      low_run  = cpu_ready ? 0 : low_run + 1;
      prev_rnw = sprdma_r_nw;
      prev_act = active;
      prev_rdy = cpu_ready;
    end
  end

  typedef struct {
    logic [15:0] a;
    logic        r_nw;
    logic [7:0]  d;
    logic        exp_act;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{a: 16'h4013, r_nw: 1'b0, d: 8'h03, exp_act: 1'b0};
    vecs[1] = '{a: 16'h4015, r_nw: 1'b0, d: 8'h03, exp_act: 1'b0};
    vecs[2] = '{a: 16'h4014, r_nw: 1'b1, d: 8'h03, exp_act: 1'b0};
    vecs[3] = '{a: 16'h4014, r_nw: 1'b0, d: 8'h03, exp_act: 1'b1};
    vecs[4] = '{a: 16'h2004, r_nw: 1'b0, d: 8'h03, exp_act: 1'b0};

    rst_n    = 1'b0;
    ready    = 1'b1;
    cpu_a    = 16'h0000;
    cpu_dout = 8'h00;
    cpu_r_nw = 1'b1;
    step();
    step();
    chk("rst_active", 32'(active), 0);
    chk("rst_cpu_ready", 32'(cpu_ready), 1);
    chk("rst_a", 32'(sprdma_a), 0);
    chk("rst_dout", 32'(sprdma_dout), 0);
    chk("rst_r_nw", 32'(sprdma_r_nw), 1);
    rst_n = 1'b1;
    step();

    // Single CPU bus operations: only a write to $4014 starts a transfer.
    for (int v = 0; v < 5; v++) begin
      xfers = 0;
      if (vecs[v].exp_act) push_page(vecs[v].d);
      cpu_op(vecs[v].a, vecs[v].r_nw, vecs[v].d, 2);
      step();
      chk($sformatf("vec%0d_active", v), 32'(active), 32'(vecs[v].exp_act));
      chk($sformatf("vec%0d_cpu_ready", v), 32'(cpu_ready), 32'(!vecs[v].exp_act));
      if (vecs[v].exp_act) begin
        wait_done(3000);
        chk("basic_stall", last_stall, 2052);
        chk("basic_sb_empty", sb_q.size(), 0);
      end
      step();
      step();
      chk($sformatf("vec%0d_idle", v), 32'(active), 0);
      chk($sformatf("vec%0d_xfers", v), xfers, vecs[v].exp_act ? 1 : 0);
    end

    // Write hold: trig high for 8 clocks; DUMMY must wait for the first low sample.
    push_page(8'h04);
    cpu_a    = 16'h4014;
    cpu_r_nw = 1'b0;
    cpu_dout = 8'h04;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("hold_active", 32'(active), 0);
      chk("hold_cpu_ready", 32'(cpu_ready), 1);
    end
    cpu_a    = 16'h0000;
    cpu_r_nw = 1'b1;
    step();
    chk("hold_dummy_start", 32'(active), 1);
    chk("hold_dummy_addr", 32'(sprdma_a), 32'h0400);
    wait_done(3000);
    chk("hold_stall", last_stall, 2052);
    chk("hold_sb_empty", sb_q.size(), 0);

    // Ready stall: 5 clocks of ready=0 during READ of idx 10.
    push_page(8'h03);
    cpu_op(16'h4014, 1'b0, 8'h03, 1);
    wait_addr(16'h0310, 1'b1, 400);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_addr_hold", 32'(sprdma_a), 32'h0310);
      chk("stall_active", 32'(active), 1);
    end
    ready = 1'b1;
    wait_done(3000);
    chk("ready_stall_len", last_stall, 2057);
    chk("ready_sb_empty", sb_q.size(), 0);

    // Reset during WRITE of idx 80, then restart from page 7.
    push_page(8'h01);
    cpu_op(16'h4014, 1'b0, 8'h01, 1);
    wait_addr(16'h0180, 1'b1, 1500);
    wait_addr(16'h2004, 1'b0, 20);
    rst_n = 1'b0;
    step();
    chk("midrst_active", 32'(active), 0);
    chk("midrst_cpu_ready", 32'(cpu_ready), 1);
    chk("midrst_r_nw", 32'(sprdma_r_nw), 1);
    chk("midrst_a", 32'(sprdma_a), 0);
    rst_n = 1'b1;
    sb_q.delete();
    step();
    push_page(8'h07);
    cpu_op(16'h4014, 1'b0, 8'h07, 1);
    step();
    chk("restart_addr", 32'(sprdma_a), 32'h0700);
    wait_done(3000);
    chk("restart_stall", last_stall, 2052);
    chk("restart_sb_empty", sb_q.size(), 0);

    // Retrigger with 05 during a page-2 transfer must be ignored.
    step();
    xfers = 0;
    push_page(8'h02);
    cpu_op(16'h4014, 1'b0, 8'h02, 1);
    repeat (20) step();
    cpu_op(16'h4014, 1'b0, 8'h05, 2);
    wait_done(3000);
    chk("retrig_sb_empty", sb_q.size(), 0);
    repeat (4) step();
    chk("retrig_idle", 32'(active), 0);
    chk("retrig_xfers", xfers, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
